// File: rtl/debug_uart_tx.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a start/data/stop serialiser with AVR block flow control.
// Build option: define DEBUG_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module debug_uart_tx #(
    parameter int CLK_PER_BIT = 50,
    parameter int DEPTH_LOG2  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            data,
    input  logic                  new_data,
    input  logic                  block,
    output logic                  busy,
    output logic                  tx,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0]         CYC_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [DEPTH_LOG2:0]   FULL     = (DEPTH_LOG2 + 1)'(DEPTH);

`ifdef DEBUG_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    // ------------------------------------------------------------------
    // Write handshake: new_data is the valid, !busy is the ready. A byte is
    // accepted only on a cycle where both are high; a valid while not ready
    // drops the byte and latches overflow until reset.
    // ------------------------------------------------------------------
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  wr_en;
    logic                  pop;
    logic [7:0]            head;

    assign busy  = (count == FULL);
    assign level = count;
    assign wr_en = new_data && !busy;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (new_data && busy) begin
                overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    state_t        state, state_n;
    logic [CW-1:0] cyc, cyc_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n;
    logic          cyc_done;
`ifdef DEBUG_UART_TX_PARITY_EN
    logic          par, par_n;
`endif

    assign cyc_done = (cyc == CYC_LAST);

    always_comb begin
        state_n = state;
        cyc_n   = cyc;
        bit_n   = bit_idx;
        shift_n = shift;
        pop     = 1'b0;
`ifdef DEBUG_UART_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            S_IDLE: begin
                // count is registered, so a byte written this cycle is not visible yet
                if ((count != '0) && !block) begin
                    pop     = 1'b1;
                    shift_n = head;
                    cyc_n   = '0;
                    bit_n   = '0;
`ifdef DEBUG_UART_TX_PARITY_EN
                    par_n   = ^head;
`endif
                    state_n = S_START;
                end
            end
            S_START: begin
                if (cyc_done) begin
                    cyc_n   = '0;
                    bit_n   = '0;
                    state_n = S_DATA;
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            S_DATA: begin
                if (cyc_done) begin
                    cyc_n   = '0;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
`ifdef DEBUG_UART_TX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
`ifdef DEBUG_UART_TX_PARITY_EN
            S_PARITY: begin
                if (cyc_done) begin
                    cyc_n   = '0;
                    state_n = S_STOP;
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (cyc_done) begin
                    cyc_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cyc_n   = '0;
            end
        endcase
    end

    // Line level is decoded from the next state so tx comes straight from a flop.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shift_n[0];
`ifdef DEBUG_UART_TX_PARITY_EN
            S_PARITY: tx_n = par_n;
`endif
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cyc     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
`ifdef DEBUG_UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cyc     <= cyc_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            tx      <= tx_n;
`ifdef DEBUG_UART_TX_PARITY_EN
            par     <= par_n;
`endif
        end
    end

endmodule
